// File: rtl/wb_irq_timer_pkg.sv
// ---------------------------------------------------------------------------
// wb_irq_timer_pkg
// Shared constants for the wishbone interrupt timer: register word offsets,
// CTRL bit positions and a byte-lane merge helper used for partial writes.
// ---------------------------------------------------------------------------
package wb_irq_timer_pkg;

  // Register word offsets, decoded from wb_adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_PRE_LSB  = 8;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_irq_timer_prescaler.sv
// ---------------------------------------------------------------------------
// wb_irq_timer_prescaler
// Free-running divider that counts 0..div and flags the cycle in which the
// count equals div. A div of 0 therefore flags every cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear of the count (held while the timer is disabled
//          and pulsed on every CTRL write)
//   div  - terminal count
//   tick - high in the cycle where the count equals div
// ---------------------------------------------------------------------------
module wb_irq_timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] div,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;

  // The tick is purely combinational so that the top can act on it at the
  // very next edge; the top gates it with EN.
  assign tick = (cnt_q == div);

  // Counter wraps to 0 on the tick cycle and is forced to 0 by clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_irq_timer.sv
// ---------------------------------------------------------------------------
// wb_irq_timer
// Wishbone B3 classic slave with a programmable down-counting timer that
// raises a level interrupt. Accesses are acknowledged one cycle after the
// request; writes commit and read data is captured on the ack edge.
// Ports:
//   wb_clk_i, wb_rst_i  - clock, synchronous active-high reset
//   wb_adr_i            - byte address, [3:2] select CTRL/LOAD/COUNT/STATUS
//   wb_dat_i, wb_sel_i  - write data and byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i - bus control
//   wb_dat_o, wb_ack_o  - read data (zero outside the ack) and acknowledge
//   wb_err_o            - always 0
//   irq_o               - registered PEND & IE
// ---------------------------------------------------------------------------
module wb_irq_timer
  import wb_irq_timer_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        irq_o
);

  logic                      en_q;
  logic                      periodic_q;
  logic                      ie_q;
  logic [PRESCALE_WIDTH-1:0] pre_q;
  logic [COUNT_WIDTH-1:0]    load_q;
  logic [COUNT_WIDTH-1:0]    count_q;
  logic                      pend_q;
  logic                      irq_q;
  logic                      ack_q;
  logic [31:0]               dat_q;

  logic        req;
  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic        status_clr;
  logic [31:0] ctrl_rd;
  logic [31:0] rd_val;
  logic [31:0] ctrl_merged;
  logic [31:0] load_merged;
  logic [31:0] count_merged;
  logic        tick;
  logic        tick_en;
  logic        expire;
  logic        unused_bits;

  assign wb_err_o = 1'b0;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

  // A new request is only accepted while no ack is outstanding, which limits
  // the slave to one ack every two cycles.
  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign reg_sel = wb_adr_i[3:2];

  assign wr_ctrl    = req & wb_we_i & (reg_sel == REG_CTRL);
  assign wr_load    = req & wb_we_i & (reg_sel == REG_LOAD);
  assign wr_count   = req & wb_we_i & (reg_sel == REG_COUNT);
  assign wr_status  = req & wb_we_i & (reg_sel == REG_STATUS);
  assign status_clr = wr_status & wb_sel_i[0] & wb_dat_i[0];

  // CTRL as seen by software; undefined bits read 0
  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_EN]                        = en_q;
    ctrl_rd[CTRL_PERIODIC]                  = periodic_q;
    ctrl_rd[CTRL_IE]                        = ie_q;
    ctrl_rd[CTRL_PRE_LSB +: PRESCALE_WIDTH] = pre_q;
  end

  // Partial writes are merged against the current register contents
  assign ctrl_merged  = merge_bytes(ctrl_rd, wb_dat_i, wb_sel_i);
  assign load_merged  = merge_bytes(32'(load_q), wb_dat_i, wb_sel_i);
  assign count_merged = merge_bytes(32'(count_q), wb_dat_i, wb_sel_i);

  // Read mux
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:   rd_val = ctrl_rd;
      REG_LOAD:   rd_val = 32'(load_q);
      REG_COUNT:  rd_val = 32'(count_q);
      REG_STATUS: rd_val = {31'd0, pend_q};
      default:    rd_val = '0;
    endcase
  end

  wb_irq_timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .clr  (wr_ctrl | ~en_q),
    .div  (pre_q),
    .tick (tick)
  );

  // A tick only counts while enabled; COUNT of 0 or 1 means this tick ends
  // the period, so LOAD=0 behaves like LOAD=1.
  assign tick_en = tick & en_q;
  assign expire  = tick_en & (count_q <= COUNT_WIDTH'(1));

  // Bus handshake: ack and read data are registered from the request cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req & ~wb_we_i) ? rd_val : '0;
    end
  end

  // CTRL: a software write overrides the one-shot auto-disable
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      pre_q      <= '0;
    end else if (wr_ctrl) begin
      en_q       <= ctrl_merged[CTRL_EN];
      periodic_q <= ctrl_merged[CTRL_PERIODIC];
      ie_q       <= ctrl_merged[CTRL_IE];
      pre_q      <= ctrl_merged[CTRL_PRE_LSB +: PRESCALE_WIDTH];
    end else if (expire && !periodic_q) begin
      en_q <= 1'b0;
    end
  end

  // LOAD and COUNT: software writes take priority over the counting logic;
  // a LOAD write also restarts COUNT from the written value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      load_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_load) begin
        load_q <= load_merged[COUNT_WIDTH-1:0];
      end
      if (wr_load) begin
        count_q <= load_merged[COUNT_WIDTH-1:0];
      end else if (wr_count) begin
        count_q <= count_merged[COUNT_WIDTH-1:0];
      end else if (expire) begin
        count_q <= periodic_q ? load_q : '0;
      end else if (tick_en) begin
        count_q <= count_q - COUNT_WIDTH'(1);
      end
    end
  end

  // PEND: an expiry beats a simultaneous write-1-to-clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pend_q <= 1'b0;
    end else if (expire) begin
      pend_q <= 1'b1;
    end else if (status_clr) begin
      pend_q <= 1'b0;
    end
  end

  // Interrupt output is registered, one edge behind PEND
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= pend_q & ie_q;
    end
  end

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], ctrl_merged[7:3],
                         ctrl_merged[31:CTRL_PRE_LSB+PRESCALE_WIDTH]};

endmodule

// File: doc/wb_irq_timer.md
# wb_irq_timer

Wishbone B3 classic slave providing a programmable down-counting timer that raises a level interrupt into the CPU `irq_i` vector (or1k_irq[5]). It sits on the wishbone interconnect as a peer of the UART and interrupt generator, and gives software a periodic or one-shot tick. Register accesses are single-cycle reads and writes with a registered ack.

## Interface
- `COUNT_WIDTH`, 32: width of the LOAD and COUNT registers; 1..32.
- `PRESCALE_WIDTH`, 8: width of the prescaler divisor field CTRL[8 +: PRESCALE_WIDTH]; max 16.

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, synchronous and active-high.
- `wb_adr_i`  in  32  byte address; only [3:2] decoded.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte enables, honoured on writes.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_dat_o`  out  32  read data; valid while `wb_ack_o`=1, else 0.
- `wb_ack_o`  out  1  transfer acknowledge.
- `wb_err_o`  out  1  tied 0.
- `irq_o`  out  1  interrupt, level, active-high.

## Operation
Register map (word offsets):
- 0x0 CTRL: [0] EN, [1] PERIODIC, [2] IE, [8 +: PRESCALE_WIDTH] PRE; other bits read 0.
- 0x4 LOAD: reload value; a write also copies the written value into COUNT.
- 0x8 COUNT: current value; writable.
- 0xC STATUS: [0] PEND; write-1-to-clear; other bits read 0.

Prescaler:
- Counts 0..PRE while EN=1 and emits a one-cycle `tick` when it equals PRE. PRE=0 ticks every cycle.
- Cleared to 0 on any CTRL write and while EN=0.

Counting, on each `tick`:
- If COUNT<=1, the timer expires: PEND<=1.
  - PERIODIC=1: COUNT<=LOAD.
  - PERIODIC=0: COUNT<=0 and EN<=0.
- Otherwise COUNT<=COUNT-1.
- The period is therefore max(LOAD,1)*(PRE+1) cycles.

Interrupt: `irq_o` = PEND & IE, registered.

Simultaneous events:
- Expiry and a STATUS clear in the same cycle: the set wins, so PEND stays 1.
- Expiry and a COUNT or LOAD write in the same cycle: the software value wins for COUNT, PEND is still set, and EN is still cleared if one-shot.
- CTRL write and one-shot expiry in the same cycle: the CTRL write value wins for EN.

Byte writes: only the lanes selected by `wb_sel_i` update. Bits above COUNT_WIDTH are ignored on write and read 0.

Reset values:
- CTRL, LOAD, COUNT, PEND and the prescaler are 0.
- `wb_ack_o`, `wb_dat_o` and `irq_o` are 0.
- Reset mid-transfer drops the ack with no register update.

## Timing
- Ack: `wb_ack_o` rises exactly one cycle after the first cycle with `wb_cyc_i & wb_stb_i & ~wb_ack_o`, for one cycle.
  - The strobe stays high for two cycles per access, so there is at most one ack every two cycles.
- Write commit: the register write takes effect in the ack cycle (same edge that raises the ack). Read data is sampled from register state at that edge.
- Interrupt latency: the expiry-causing tick sets PEND at edge n; `irq_o` rises at edge n+1.
- Clear latency: a STATUS clear commits with its ack at edge n; `irq_o` falls at edge n+1.
- Start-up: enabling via a CTRL write at edge n puts the first tick at edge n+PRE+1.

## Structure
- Package `wb_irq_timer_pkg`:
  - register offset constants (CTRL=2'd0, LOAD=2'd1, COUNT=2'd2, STATUS=2'd3);
  - CTRL bit-position constants EN=0, PERIODIC=1, IE=2, PRE_LSB=8.
- Sub-module `wb_irq_timer_prescaler`: inputs `clr` and `div`; output `tick`; sequential counter as defined above.
- Top holds the bus decode, the registers, the expiry logic and the irq register.

## Test plan
- Reset then read all four registers -> every read returns 0x00000000; `irq_o`=0; each ack lasts exactly one cycle.
- LOAD=5, CTRL=0x7 (EN, PERIODIC, IE, PRE=0) -> `irq_o` rises 6 cycles after the CTRL ack edge (5 ticks + 1 register). Write STATUS=1 -> `irq_o` falls. The next rise comes 5 cycles after the previous expiry.
- One-shot: LOAD=3, CTRL=0x0305 (EN, IE, PRE=3) -> expiry after 12 cycles. CTRL then reads 0x0304 (EN cleared), COUNT=0, and the timer does not fire again.
- STATUS clear written in the exact expiry cycle (periodic, LOAD=1) -> PEND reads 1 and `irq_o` stays 1.
- Byte write: `wb_sel_i`=4'b0001, data 0xAABBCCDD to LOAD, previously 0x11223344 -> LOAD and COUNT both read 0x112233DD.
- `wb_rst_i` asserted while COUNT=2 and PEND=1 -> on the next edge all registers are 0, `irq_o`=0 and `wb_ack_o`=0.
